ysyx_24090018_wbu: RTL and testbench
====================================

// Module: ysyx_24090018_wbu
// PURPOSE
//   Write-back stage of the NPC core; sits directly upstream of the register file's per-register write ports.
//   Accepts one retiring instruction per handshake from EXU. For loads it waits for the LSU response,
//   then extracts and extends the loaded data.
//   Emits a single-cycle register-file write (wen/addr/data) plus commit status for difftest/trace.
// PARAMETERS
//   XLEN   32  datapath width (loads: 32 only)
//   REG_AW 5   register index width
//   CNT_W  32  retired-instruction counter width
// PORTS
//   clk          in  1      clock, all state on posedge
//   rst          in  1      asynchronous, active-low reset
//   in_valid     in  1      EXU presents a retiring instruction
//   in_ready     out 1      WBU can accept this cycle
//   in_pc        in  XLEN   instruction PC
//   in_rd        in  REG_AW destination register index
//   in_rd_wen    in  1      instruction writes rd
//   in_result    in  XLEN   ALU/CSR result (non-load)
//   in_is_load   in  1      instruction is a load
//   in_funct3    in  3      load type
//   in_addr_lo   in  2      load address bits [1:0]
//   mem_rvalid   in  1      LSU read data valid
//   mem_rdata    in  XLEN   LSU read word (aligned)
//   mem_err      in  1      LSU access fault, qualified by mem_rvalid
//   rf_wen       out 1      register-file write enable
//   rf_waddr     out REG_AW register-file write index
//   rf_wdata     out XLEN   register-file write data
//   commit_valid out 1      one-cycle retire pulse
//   commit_pc    out XLEN   PC of retiring instruction
//   commit_cnt   out CNT_W  retired-instruction count
//   err          out 1      sticky fault flag
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE.
//     rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_cnt and err all =0.
//   FSM states: IDLE, WAIT_MEM, COMMIT.
//     in_ready=1 in IDLE and COMMIT; in_ready=0 in WAIT_MEM.
//   Accept = in_valid & in_ready; all in_* fields are captured on accept.
//     Accept with !in_is_load -> COMMIT next cycle.
//     Accept with in_is_load -> WAIT_MEM.
//   WAIT_MEM: holds until mem_rvalid=1.
//     Extended data is captured on that edge -> COMMIT.
//     mem_rvalid is sampled ONLY in WAIT_MEM; ignored in IDLE/COMMIT, including the accept cycle.
//   COMMIT (exactly one cycle):
//     commit_valid=1; commit_pc=captured pc; commit_cnt increments by 1 (wraps mod 2^CNT_W).
//     rf_wen=1 iff rd_wen & rd!=0 & !fault.
//     Next state: COMMIT again if accept this cycle, else IDLE (back-to-back = one commit per cycle).
//   rf_wen/commit_valid are registered, high only in COMMIT.
//     rf_waddr/rf_wdata hold their last values otherwise.
//   Latency: non-load accepted at cycle N -> rf_wen at N+1; load rvalid at cycle M -> rf_wen at M+1.
//   Load extension (byte lane chosen by in_addr_lo):
//     000 LB  sign-ext byte; 100 LBU zero-ext byte.
//     001 LH  sign-ext half at addr_lo[1]; 101 LHU zero-ext half at addr_lo[1]; addr_lo[0] ignored for halves.
//     010 LW  full word.
//     Any other funct3: fault.
//   Fault (mem_err with mem_rvalid, or illegal funct3): instruction still commits (commit_valid=1, cnt++).
//     rf_wen suppressed; err set to 1 and held until reset.
//   Reset mid-WAIT_MEM or COMMIT: transaction dropped, no write issued, counter cleared.
// TESTING
//   1. ALU op rd=5, result=0x0000_1234, accepted at cycle N -> cycle N+1: rf_wen=1, waddr=5,
//      wdata=0x1234, commit_cnt=1.
//   2. LB addr_lo=3, rdata=0x80FF_0000 -> wdata=0xFFFF_FF80;
//      LHU addr_lo=2, rdata=0x8001_0000 -> wdata=0x0000_8001.
//   3. rd=0, rd_wen=1 -> rf_wen=0, commit_valid=1, cnt increments.
//   4. Three ALU ops on consecutive cycles -> three consecutive rf_wen pulses, in_ready stays 1.
//      With CNT_W=4, 16 commits -> commit_cnt=0.
//   5. Load, then mem_rvalid=1 with mem_err=1 -> no rf_wen, commit_valid=1, err=1 stays high
//      through later commits.
//   6. rst=0 asserted in WAIT_MEM -> outputs 0 immediately; after release in_ready=1
//      and a stale mem_rvalid is ignored.

Source files
------------

// File: rtl/ysyx_24090018_wbu_if.sv
// ysyx_24090018_wbu_if
//   Bundles every non-clock/reset signal of the write-back unit.
//   Groups: EXU retire handshake (in_*), LSU read response (mem_*),
//   register-file write port (rf_*), commit/trace status (commit_*, err).
//   master: the surrounding pipeline (EXU/LSU driver, RF/trace sink).
//   slave : the write-back unit itself.
//
// Handshake: a retiring instruction transfers on a rising clk edge where
// in_valid & in_ready are both 1. in_valid may rise regardless of in_ready,
// and the in_* fields must stay stable while in_valid is high and in_ready is low.
// mem_rvalid is a one-shot response qualifier with no back-pressure.
// mem_rdata/mem_err are meaningful only when mem_rvalid is 1.
interface ysyx_24090018_wbu_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_wen;
    logic [XLEN-1:0]   in_result;
    logic              in_is_load;
    logic [2:0]        in_funct3;
    logic [1:0]        in_addr_lo;

    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic [CNT_W-1:0]  commit_cnt;
    logic              err;

    modport master (
        output in_valid, in_pc, in_rd, in_rd_wen, in_result, in_is_load,
               in_funct3, in_addr_lo, mem_rvalid, mem_rdata, mem_err,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid,
               commit_pc, commit_cnt, err
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rd_wen, in_result, in_is_load,
               in_funct3, in_addr_lo, mem_rvalid, mem_rdata, mem_err,
        output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid,
               commit_pc, commit_cnt, err
    );
endinterface

// File: rtl/ysyx_24090018_wbu.sv
// ysyx_24090018_wbu
//   Write-back stage of the NPC core. Accepts one retiring instruction per
//   handshake from the EXU; loads wait for the LSU response and have their
//   byte/half/word lane extracted and extended. Every retirement produces a
//   single-cycle register-file write plus a commit pulse for difftest/trace.
// Ports
//   clk       : clock, all state on posedge
//   rst       : asynchronous active-low reset
//   bus       : ysyx_24090018_wbu_if.slave (EXU handshake, LSU response,
//               RF write port, commit status, sticky err)
//   dbg_state : current FSM state (0 IDLE, 1 WAIT_MEM, 2 COMMIT)
module ysyx_24090018_wbu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_24090018_wbu_if.slave       bus,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_e;

    state_e            state_q, state_d;

    // Fields captured on accept; only the load path reads them later.
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rd_wen_q, rd_wen_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

    // Registered outputs.
    logic              rf_wen_q, rf_wen_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              commit_valid_q, commit_valid_d;
    logic [XLEN-1:0]   commit_pc_q, commit_pc_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
    logic              err_q, err_d;

    logic              in_ready;
    logic              accept;

    // Retirement event for the edge at the end of this cycle.
    logic              ret_valid;
    logic [XLEN-1:0]   ret_pc;
    logic [REG_AW-1:0] ret_rd;
    logic              ret_rd_wen;
    logic [XLEN-1:0]   ret_data;
    logic              ret_fault;

    // Load extraction from the aligned LSU word.
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_data;
    logic              load_illegal;

    assign in_ready = (state_q != WAIT_MEM);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        ld_byte      = 8'h00;
        ld_half      = 16'h0000;
        load_data    = '0;
        load_illegal = 1'b0;

        case (addr_lo_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase

        // Halves select on addr_lo[1] only; a misaligned bit 0 is not checked here.
        ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            3'b010:  load_data = bus.mem_rdata;
            default: load_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        rd_wen_d       = rd_wen_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;

        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        commit_cnt_d   = commit_cnt_q;
        err_d          = err_q;

        ret_valid      = 1'b0;
        ret_pc         = '0;
        ret_rd         = '0;
        ret_rd_wen     = 1'b0;
        ret_data       = '0;
        ret_fault      = 1'b0;

        case (state_q)
            IDLE, COMMIT: begin
                if (accept) begin
                    pc_d      = bus.in_pc;
                    rd_d      = bus.in_rd;
                    rd_wen_d  = bus.in_rd_wen;
                    funct3_d  = bus.in_funct3;
                    addr_lo_d = bus.in_addr_lo;
                    if (bus.in_is_load) begin
                        // mem_rvalid on the accept cycle belongs to nobody.
                        state_d = WAIT_MEM;
                    end else begin
                        state_d    = COMMIT;
                        ret_valid  = 1'b1;
                        ret_pc     = bus.in_pc;
                        ret_rd     = bus.in_rd;
                        ret_rd_wen = bus.in_rd_wen;
                        ret_data   = bus.in_result;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d    = COMMIT;
                    ret_valid  = 1'b1;
                    ret_pc     = pc_q;
                    ret_rd     = rd_q;
                    ret_rd_wen = rd_wen_q;
                    ret_data   = load_data;
                    ret_fault  = bus.mem_err | load_illegal;
                end
            end
            default: state_d = IDLE;
        endcase

        // A faulting instruction still retires; only the RF write is dropped.
        if (ret_valid) begin
            commit_valid_d = 1'b1;
            commit_pc_d    = ret_pc;
            commit_cnt_d   = commit_cnt_q + CNT_W'(1);
            rf_wen_d       = ret_rd_wen & (ret_rd != '0) & ~ret_fault;
            rf_waddr_d     = ret_rd;
            rf_wdata_d     = ret_data;
            if (ret_fault) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_cnt_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_cnt_q   <= commit_cnt_d;
            err_q          <= err_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.rf_wen       = rf_wen_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_pc    = commit_pc_q;
    assign bus.commit_cnt   = commit_cnt_q;
    assign bus.err          = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ysyx_24090018_wbu.sv
// tb_ysyx_24090018_wbu
//   Directed bench for the write-back unit, built with a 4-bit commit
//   counter so the wrap-around is reachable. Each driver pushes the expected
//   commit record when it drives the retiring stimulus; the per-cycle monitor
//   pops and compares it one cycle later, and checks idle cycles for silence.
module tb_ysyx_24090018_wbu;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic [3:0]  cnt;
        logic        err;
    } commit_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ysyx_24090018_wbu_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    ysyx_24090018_wbu #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Scoreboard and reference state.
    commit_t     exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic        waiting = 1'b0;
    logic [3:0]  exp_cnt = 4'd0;
    logic        model_err = 1'b0;
    logic        cur_err = 1'b0;
    logic [31:0] ld_pc;
    logic [4:0]  ld_rd;
    logic        ld_wen;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference load extraction, written with shifts and signed casts.
    task automatic model_load(input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] rdata,
                              output logic [31:0] data, output logic bad);
        logic [31:0] sh;
        logic [31:0] hs;
        sh  = rdata >> (8 * lo);
        hs  = lo[1] ? (rdata >> 16) : rdata;
        bad = 1'b0;
        data = 32'h0;
        case (f3)
            3'b000:  data = 32'($signed(sh[7:0]));
            3'b100:  data = {24'h0, sh[7:0]};
            3'b001:  data = 32'($signed(hs[15:0]));
            3'b101:  data = {16'h0, hs[15:0]};
            3'b010:  data = rdata;
            default: bad = 1'b1;
        endcase
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic wen, input logic fault);
        commit_t e;
        exp_cnt = exp_cnt + 4'd1;
        if (fault) model_err = 1'b1;
        e.pc   = pc;
        e.rd   = rd;
        e.data = data;
        e.wen  = wen & (rd != 5'd0) & ~fault;
        e.cnt  = exp_cnt;
        e.err  = model_err;
        exp_q.push_back(e);
    endtask

    // One clock, then sample 1 ns after the edge and check everything visible.
    task automatic cycle();
        commit_t e;
        logic [1:0] exp_state;
        @(posedge clk);
        #1;
        chk("in_ready", bus.in_ready, !waiting);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_state = waiting ? 2'd1 : 2'd2;
            chk("commit_valid", bus.commit_valid, 1'b1);
            chk("commit_pc", bus.commit_pc, e.pc);
            chk("commit_cnt", bus.commit_cnt, e.cnt);
            chk("rf_wen", bus.rf_wen, e.wen);
            chk("err", bus.err, e.err);
            cur_err = e.err;
            if (e.wen) begin
                chk("rf_waddr", bus.rf_waddr, e.rd);
                chk("rf_wdata", bus.rf_wdata, e.data);
            end
        end else begin
            exp_state = waiting ? 2'd1 : 2'd0;
            chk("commit_valid_idle", bus.commit_valid, 1'b0);
            chk("rf_wen_idle", bus.rf_wen, 1'b0);
            chk("err_hold", bus.err, cur_err);
        end
        chk("dbg_state", dbg_state, exp_state);
    endtask

    task automatic drive_alu(input logic [31:0] pc, input logic [4:0] rd,
                             input logic wen, input logic [31:0] result);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_pc      = pc;
        bus.in_rd      = rd;
        bus.in_rd_wen  = wen;
        bus.in_result  = result;
        bus.in_funct3  = 3'($urandom_range(0, 7));
        bus.in_addr_lo = 2'($urandom_range(0, 3));
        push(pc, rd, result, wen, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                              input logic [2:0] f3, input logic [1:0] lo, input logic stale);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_pc      = pc;
        bus.in_rd      = rd;
        bus.in_rd_wen  = wen;
        bus.in_result  = $urandom;
        bus.in_funct3  = f3;
        bus.in_addr_lo = lo;
        bus.mem_rvalid = stale;
        bus.mem_rdata  = $urandom;
        bus.mem_err    = stale;
        ld_pc   = pc;
        ld_rd   = rd;
        ld_wen  = wen;
        ld_f3   = f3;
        ld_lo   = lo;
        waiting = 1'b1;
        cycle();
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_err    = 1'b0;
    endtask

    // Idle gap cycles present a competing instruction that must not be taken.
    task automatic mem_resp(input logic [31:0] rdata, input logic merr, input int gap);
        logic [31:0] d;
        logic        bad;
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_rd      = 5'd9;
        bus.in_rd_wen  = 1'b1;
        repeat (gap) cycle();
        bus.in_valid = 1'b0;
        model_load(ld_f3, ld_lo, rdata, d, bad);
        push(ld_pc, ld_rd, d, ld_wen, bad | merr);
        waiting        = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        bus.mem_err    = merr;
        cycle();
        bus.mem_rvalid = 1'b0;
        bus.mem_err    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_wen"}, bus.rf_wen, 1'b0);
        chk({tag, "_rf_waddr"}, bus.rf_waddr, 5'd0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 32'h0);
        chk({tag, "_commit_valid"}, bus.commit_valid, 1'b0);
        chk({tag, "_commit_pc"}, bus.commit_pc, 32'h0);
        chk({tag, "_commit_cnt"}, bus.commit_cnt, 4'd0);
        chk({tag, "_err"}, bus.err, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_state"}, dbg_state, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        // Clock/reset.
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_pc      = '0;
        bus.in_rd      = '0;
        bus.in_rd_wen  = 1'b0;
        bus.in_result  = '0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = 3'b000;
        bus.in_addr_lo = 2'b00;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        cycle();

        // Single ALU op: commit with rd=5, 0x1234, count 1 one cycle later.
        drive_alu(32'h8000_0000, 5'd5, 1'b1, 32'h0000_1234);
        cycle();

        // LB at byte 3 with a stale rvalid on the accept cycle, then LHU upper half.
        drive_load(32'h8000_0004, 5'd6, 1'b1, 3'b000, 2'd3, 1'b1);
        mem_resp(32'h80FF_0000, 1'b0, 2);
        drive_load(32'h8000_0008, 5'd7, 1'b1, 3'b101, 2'd2, 1'b0);
        mem_resp(32'h8001_0000, 1'b0, 0);
        // LH with addr_lo=1 selects the low half; LBU and LW.
        drive_load(32'h8000_000C, 5'd8, 1'b1, 3'b001, 2'd1, 1'b0);
        mem_resp(32'h1234_9ABC, 1'b0, 1);
        drive_load(32'h8000_0010, 5'd10, 1'b1, 3'b100, 2'd1, 1'b0);
        mem_resp(32'h0000_F100, 1'b0, 0);
        drive_load(32'h8000_0014, 5'd11, 1'b1, 3'b010, 2'd0, 1'b0);
        mem_resp(32'hDEAD_BEEF, 1'b0, 3);
        cycle();

        // rd=0 with rd_wen=1, and rd_wen=0: commit without a write.
        drive_alu(32'h8000_0018, 5'd0, 1'b1, 32'hFFFF_FFFF);
        drive_alu(32'h8000_001C, 5'd12, 1'b0, 32'h5555_5555);
        cycle();

        // Back-to-back ALU ops, then a load accepted straight out of COMMIT.
        drive_alu(32'h8000_0020, 5'd1, 1'b1, 32'h0000_0001);
        drive_alu(32'h8000_0024, 5'd2, 1'b1, 32'h0000_0002);
        drive_alu(32'h8000_0028, 5'd3, 1'b1, 32'h0000_0003);
        drive_load(32'h8000_002C, 5'd4, 1'b1, 3'b010, 2'd0, 1'b0);
        mem_resp(32'hCAFE_F00D, 1'b0, 0);
        // Another ALU op right out of the load's COMMIT cycle.
        drive_alu(32'h8000_0030, 5'd13, 1'b1, 32'h0000_0013);
        cycle();

        // Randomised legal loads.
        for (int i = 0; i < 6; i++) begin
            drive_load(32'h8000_1000 + 32'(4 * i), 5'($urandom_range(1, 31)), 1'b1,
                       f3_tab[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), 1'b0);
            mem_resp($urandom, 1'b0, $urandom_range(0, 3));
        end
        cycle();

        // Access fault: commits without a write, err becomes sticky.
        drive_load(32'h8000_0040, 5'd14, 1'b1, 3'b010, 2'd0, 1'b0);
        mem_resp(32'h1111_2222, 1'b1, 1);
        drive_alu(32'h8000_0044, 5'd15, 1'b1, 32'h0000_0044);
        // Illegal funct3 also faults.
        drive_load(32'h8000_0048, 5'd16, 1'b1, 3'b011, 2'd0, 1'b0);
        mem_resp(32'h3333_4444, 1'b0, 0);
        drive_alu(32'h8000_004C, 5'd17, 1'b1, 32'h0000_004C);
        cycle();
        cycle();

        // Reset while in WAIT_MEM: outputs clear at once, stale rvalid ignored later.
        drive_load(32'h8000_0050, 5'd18, 1'b1, 3'b010, 2'd0, 1'b0);
        cycle();
        #2;
        rst = 1'b0;
        #1;
        waiting   = 1'b0;
        exp_cnt   = 4'd0;
        model_err = 1'b0;
        cur_err   = 1'b0;
        exp_q.delete();
        check_reset_outputs("midreset");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        repeat (2) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        bus.mem_rvalid = 1'b0;

        // 16 back-to-back commits wrap the 4-bit counter to 0.
        for (int i = 0; i < 16; i++) begin
            drive_alu(32'h8000_2000 + 32'(4 * i), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom);
        end
        chk("cnt_wrap", bus.commit_cnt, 4'd0);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
